xadc_monitor: RTL

XADC_MONITOR -- requirements
Module: xadc_monitor

---
 rtl/xadc_monitor_pkg.sv | 34 +++
 rtl/xadc_drp_reader.sv | 76 +++++++
 rtl/xadc_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/xadc_monitor_pkg.sv
// Shared types and constants for the XADC polling monitor.
package xadc_monitor_pkg;

    // Polling sequence: request a conversion result, wait for it, store it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    // Register offsets relative to the block's base address.
    localparam int unsigned OFF_CTRL    = 0;
    localparam int unsigned OFF_ALARM   = 1;
    localparam int unsigned OFF_CH_BASE = 2;
    localparam int unsigned CH_STRIDE   = 4;

    // Position of each register inside one channel's group of four.
    localparam int unsigned CH_CUR    = 0;
    localparam int unsigned CH_MIN    = 1;
    localparam int unsigned CH_MAX    = 2;
    localparam int unsigned CH_THRESH = 3;

    // Default DRP addresses of the on-chip sensors.
    localparam logic [6:0] DRP_ADDR_TEMP   = 7'h00;
    localparam logic [6:0] DRP_ADDR_VCCINT = 7'h01;
    localparam logic [6:0] DRP_ADDR_VCCAUX = 7'h02;

    // Offset of register regSel belonging to channel ch.
    function automatic int unsigned chRegOffset(input int unsigned ch, input int unsigned regSel);
        return OFF_CH_BASE + CH_STRIDE * ch + regSel;
    endfunction

endpackage

// File: rtl/xadc_drp_reader.sv
// Issues one DRP read per start request and waits (bounded) for the result.
module xadc_drp_reader
    import xadc_monitor_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [6:0]  i_daddr,
    input  logic [15:0] i_drpDo,
    input  logic        i_drpDrdy,
    output logic [6:0]  o_drpDaddr,
    output logic        o_drpDen,
    output logic [11:0] o_code,
    output logic        o_done,
    output logic        o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_den;
    logic [6:0]         r_daddr;
    logic [11:0]        r_code;
    logic               w_unusedLowBits;

    // The four status bits below the 12-bit conversion code carry no data.
    assign w_unusedLowBits = ^i_drpDo[3:0];

    // Request/wait sequencer; a drdy seen outside WAIT never reaches r_code.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_den   <= 1'b0;
            r_daddr <= '0;
            r_code  <= '0;
        end else begin
            r_den <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_REQ;
                        r_den   <= 1'b1;
                        r_daddr <= i_daddr;
                    end
                end
                ST_REQ: begin
                    r_state <= ST_WAIT;
                    r_count <= '0;
                end
                ST_WAIT: begin
                    if (i_drpDrdy) begin
                        r_code  <= i_drpDo[15:4];
                        r_state <= ST_STORE;
                    end else if (r_count == CNT_W'(TIMEOUT - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_STORE: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_drpDaddr = r_daddr;
    assign o_drpDen   = r_den;
    assign o_code     = r_code;
    assign o_done     = (r_state == ST_STORE);
    assign o_timeout  = (r_state == ST_WAIT) && !i_drpDrdy && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/xadc_monitor.sv
// Round-robin XADC channel poller with current/min/max/threshold registers.
module xadc_monitor
    import xadc_monitor_pkg::*;
#(
    parameter int unsigned BaseAddress   = 0,
    parameter int          address_width = 16,
    parameter int          data_width    = 8,
    parameter int          NUM_CHANNELS  = 3,
    parameter logic [NUM_CHANNELS-1:0][6:0] CHANNEL_ADDRS =
        {DRP_ADDR_VCCAUX, DRP_ADDR_VCCINT, DRP_ADDR_TEMP},
    parameter int          TIMEOUT       = 255
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    output logic [data_width-1:0]    data_o,
    input  logic                     rd_wr_i,
    output logic [6:0]               drp_daddr_o,
    output logic                     drp_den_o,
    input  logic [15:0]              drp_do_i,
    input  logic                     drp_drdy_i,
    output logic                     alarm_o
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                    r_enable;
    logic                    r_timeoutErr;
    logic [NUM_CHANNELS-1:0] r_alarm;
    logic [CH_W-1:0]         r_ch;
    logic [data_width-1:0]   r_cur    [NUM_CHANNELS];
    logic [data_width-1:0]   r_min    [NUM_CHANNELS];
    logic [data_width-1:0]   r_max    [NUM_CHANNELS];
    logic [data_width-1:0]   r_thresh [NUM_CHANNELS];
    logic [data_width-1:0]   r_data;

    logic [31:0]             w_offset;
    logic                    w_wrCtrl;
    logic                    w_wrAlarm;
    logic                    w_clearMinmax;
    logic [11:0]             w_code;
    logic                    w_done;
    logic                    w_timeout;
    logic [data_width-1:0]   w_value;
    logic [data_width-1:0]   w_rdData;

    assign w_offset      = 32'(address_i) - 32'(BaseAddress);
    assign w_wrCtrl      = rd_wr_i && (w_offset == OFF_CTRL);
    assign w_wrAlarm     = rd_wr_i && (w_offset == OFF_ALARM);
    assign w_clearMinmax = w_wrCtrl && data_i[1];

    xadc_drp_reader #(
        .TIMEOUT (TIMEOUT)
    ) u_reader (
        .i_clk      (clk_i),
        .i_reset    (reset_i),
        .i_start    (r_enable),
        .i_daddr    (CHANNEL_ADDRS[r_ch]),
        .i_drpDo    (drp_do_i),
        .i_drpDrdy  (drp_drdy_i),
        .o_drpDaddr (drp_daddr_o),
        .o_drpDen   (drp_den_o),
        .o_code     (w_code),
        .o_done     (w_done),
        .o_timeout  (w_timeout)
    );

    // Narrow buses show the top bits of the code; wide buses zero-extend it.
    generate
        if (data_width <= 12) begin : g_narrow
            assign w_value = w_code[11 -: data_width];
            if (data_width < 12) begin : g_drop
                logic w_unusedCodeLsbs;
                assign w_unusedCodeLsbs = ^w_code[11-data_width:0];
            end
        end else begin : g_wide
            assign w_value = {{(data_width-12){1'b0}}, w_code};
        end
    endgenerate

    // Read mux; anything outside the map reads as zero.
    always_comb begin
        w_rdData = '0;
        if (w_offset == OFF_CTRL) begin
            w_rdData[0] = r_enable;
            w_rdData[2] = r_timeoutErr;
        end else if (w_offset == OFF_ALARM) begin
            w_rdData[NUM_CHANNELS-1:0] = r_alarm;
        end
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (w_offset == chRegOffset(k, CH_CUR))    w_rdData = r_cur[k];
            if (w_offset == chRegOffset(k, CH_MIN))    w_rdData = r_min[k];
            if (w_offset == chRegOffset(k, CH_MAX))    w_rdData = r_max[k];
            if (w_offset == chRegOffset(k, CH_THRESH)) w_rdData = r_thresh[k];
        end
    end

    // Register file: bus writes, result capture, and channel rotation.
    // Later assignments take priority, so alarm set beats clear and minmax clear beats capture.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_enable     <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_alarm      <= '0;
            r_ch         <= '0;
            r_data       <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                r_cur[k]    <= '0;
                r_min[k]    <= '1;
                r_max[k]    <= '0;
                r_thresh[k] <= '1;
            end
        end else begin
            r_data <= w_rdData;
            if (w_wrCtrl)  r_enable     <= data_i[0];
            if (w_timeout) r_timeoutErr <= 1'b1;
            if (w_done || w_timeout) begin
                r_ch <= (r_ch == CH_W'(NUM_CHANNELS - 1)) ? '0 : r_ch + 1'b1;
            end
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (w_wrAlarm && data_i[k]) r_alarm[k] <= 1'b0;
                if (rd_wr_i && (w_offset == chRegOffset(k, CH_THRESH))) r_thresh[k] <= data_i;
                if (w_done && (r_ch == CH_W'(k))) begin
                    r_cur[k] <= w_value;
                    if (w_value < r_min[k])    r_min[k]   <= w_value;
                    if (w_value > r_max[k])    r_max[k]   <= w_value;
                    if (w_value > r_thresh[k]) r_alarm[k] <= 1'b1;
                end
                if (w_clearMinmax) begin
                    r_min[k] <= '1;
                    r_max[k] <= '0;
                end
            end
        end
    end

    assign data_o  = r_data;
    assign alarm_o = |r_alarm;

endmodule
